// File: rtl/ex_muldiv_stall_unit_if.sv
// Request/result bundle between the ID/EX pipeline register, the EX-stage
// multiply/divide unit and the EX/MEM path.
// master: pipeline side (drives the request, observes stall and result)
// slave : the multiply/divide unit
interface ex_muldiv_stall_unit_if #(
  parameter int XLEN = 32
);
  logic            ID_EX_muldiv;
  logic [2:0]      ID_EX_muldiv_op;
  logic [4:0]      ID_EX_rd;
  logic [XLEN-1:0] EX_rs1_data;
  logic [XLEN-1:0] EX_rs2_data;
  logic            EX_flush;
  logic            EX_stall;
  logic            EX_muldiv_valid;
  logic [XLEN-1:0] EX_muldiv_result;
  logic [4:0]      EX_muldiv_rd;

  modport master (
    output ID_EX_muldiv, ID_EX_muldiv_op, ID_EX_rd, EX_rs1_data, EX_rs2_data, EX_flush,
    input  EX_stall, EX_muldiv_valid, EX_muldiv_result, EX_muldiv_rd
  );

  modport slave (
    input  ID_EX_muldiv, ID_EX_muldiv_op, ID_EX_rd, EX_rs1_data, EX_rs2_data, EX_flush,
    output EX_stall, EX_muldiv_valid, EX_muldiv_result, EX_muldiv_rd
  );
endinterface

// File: rtl/ex_muldiv_stall_unit.sv
// EX-stage iterative RV32M multiply/divide unit.
// Multiplies by radix-2 shift-add and divides by restoring division, one bit
// per cycle on operand magnitudes; signs are re-applied when the result is
// registered. EX_stall freezes ID/EX until the result cycle.
// Optional feature macro: MULDIV_EARLY_OUT_EN (divide-by-zero, signed
// overflow and zero multiply operands finish without iterating).
module ex_muldiv_stall_unit #(
  parameter int XLEN = 32
) (
  input logic                   clk,
  input logic                   reset_n,
  ex_muldiv_stall_unit_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;

  // Operation context captured when the request is accepted.
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic             neg_q;   // negate product / quotient
  logic             rneg_q;  // negate remainder (dividend sign)

  // Shared datapath: multiply hi_q = partial high word, lo_q = multiplier
  // shifting out / product low word, b_q = multiplicand.
  // Divide hi_q = partial remainder, lo_q = dividend shifting out / quotient
  // shifting in, b_q = divisor.
  logic [XLEN-1:0] hi_q, lo_q, b_q;

  logic            vld_q;
  logic [XLEN-1:0] res_q;
  logic [4:0]      rd_out_q;

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  function automatic logic [XLEN-1:0] mul_result(input logic [2*XLEN-1:0] prod_mag,
                                                 input logic neg, input logic [2:0] op);
    logic [2*XLEN-1:0] prod;
    prod = neg ? -prod_mag : prod_mag;
    return (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_result(input logic [XLEN-1:0] quo, input logic [XLEN-1:0] rem,
                                                 input logic qneg, input logic rneg,
                                                 input logic [2:0] op);
    return op[1] ? apply_sign(rem, rneg) : apply_sign(quo, qneg);
  endfunction

  // Request decode: which operands are signed, their magnitudes and sign flags.
  logic signed [XLEN-1:0] a_s, b_s;
  logic [XLEN-1:0]        abs_a, abs_b;
  logic                   a_signed, b_signed, sa, sb, is_div_in, b_zero, start;

  assign a_s       = bus.EX_rs1_data;
  assign b_s       = bus.EX_rs2_data;
  assign is_div_in = bus.ID_EX_muldiv_op[2];
  assign a_signed  = bus.ID_EX_muldiv_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
  assign b_signed  = bus.ID_EX_muldiv_op inside {3'b000, 3'b001, 3'b100, 3'b110};
  assign sa        = a_signed & a_s[XLEN-1];
  assign sb        = b_signed & b_s[XLEN-1];
  assign abs_a     = sa ? -a_s : a_s;
  assign abs_b     = sb ? -b_s : b_s;
  assign b_zero    = (bus.EX_rs2_data == '0);
  assign start     = (state_q == IDLE) & bus.ID_EX_muldiv & ~bus.EX_flush;

  // Early completion: detect operations whose result needs no iteration.
  logic            early;
  logic [XLEN-1:0] early_res;
`ifdef MULDIV_EARLY_OUT_EN
  logic div_ovf;
  assign div_ovf = ((bus.ID_EX_muldiv_op == 3'b100) || (bus.ID_EX_muldiv_op == 3'b110)) &&
                   (bus.EX_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.EX_rs2_data);

  always_comb begin
    early     = 1'b0;
    early_res = '0;
    if (is_div_in) begin
      if (b_zero) begin
        early     = 1'b1;
        early_res = bus.ID_EX_muldiv_op[1] ? bus.EX_rs1_data : '1;
      end else if (div_ovf) begin
        early     = 1'b1;
        early_res = bus.ID_EX_muldiv_op[1] ? '0 : bus.EX_rs1_data;
      end
    end else if ((bus.EX_rs1_data == '0) || b_zero) begin
      early     = 1'b1;
      early_res = '0;
    end
  end
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] hi_n, lo_n, final_res;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q[2]) begin
      hi_n = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    final_res = op_q[2] ? div_result(lo_n, hi_n, neg_q, rneg_q, op_q)
                        : mul_result({hi_n, lo_n}, neg_q, op_q);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: flush or a dropped request always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = early ? DONE : CALC;
      CALC: begin
        if (bus.EX_flush || !bus.ID_EX_muldiv) state_d = IDLE;
        else if (cnt_q == '0)                  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration and result registration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      vld_q    <= 1'b0;
      res_q    <= '0;
      rd_out_q <= '0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= bus.ID_EX_muldiv_op;
            rd_q   <= bus.ID_EX_rd;
            neg_q  <= is_div_in ? ((sa ^ sb) & ~b_zero) : (sa ^ sb);
            rneg_q <= sa;
            cnt_q  <= CNT_W'(XLEN - 1);
            hi_q   <= '0;
            lo_q   <= is_div_in ? abs_a : abs_b;
            b_q    <= is_div_in ? abs_b : abs_a;
            if (early) begin
              vld_q    <= 1'b1;
              res_q    <= early_res;
              rd_out_q <= bus.ID_EX_rd;
            end
          end
        end
        CALC: begin
          if (bus.ID_EX_muldiv && !bus.EX_flush) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
              vld_q    <= 1'b1;
              res_q    <= final_res;
              rd_out_q <= rd_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.EX_stall         = bus.ID_EX_muldiv & (state_q != DONE) & ~bus.EX_flush;
  assign bus.EX_muldiv_valid  = vld_q & ~bus.EX_flush;
  assign bus.EX_muldiv_result = res_q;
  assign bus.EX_muldiv_rd     = rd_out_q;
endmodule

// File: tb/tb_ex_muldiv_stall_unit.sv
// Directed testbench for ex_muldiv_stall_unit with hand-computed results.
module tb_ex_muldiv_stall_unit;
  localparam int XLEN       = 32;
  localparam int FULL_STALL = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_STALL = 1;
`else
  localparam int EO_STALL = 33;
`endif

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  ex_muldiv_stall_unit_if #(.XLEN(XLEN)) bus();

  ex_muldiv_stall_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    bus.ID_EX_muldiv    = 1'b1;
    bus.ID_EX_muldiv_op = op;
    bus.EX_rs1_data     = a;
    bus.EX_rs2_data     = b;
    bus.ID_EX_rd        = rd;
  endtask

  // Issue one request, count stall cycles until the valid pulse, check result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_stall);
    int stalls;
    bit seen;
    stalls = 0;
    seen   = 1'b0;
    @(posedge clk); #1;
    drive_req(op, a, b, rd);
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.EX_muldiv_valid) begin
        seen = 1'b1;
        chk({tag, "_res"}, bus.EX_muldiv_result, exp_res);
        chk({tag, "_rd"}, 32'(bus.EX_muldiv_rd), 32'(rd));
        chk({tag, "_stall_at_valid"}, 32'(bus.EX_stall), 32'd0);
      end else if (bus.EX_stall) begin
        stalls++;
      end
    end
    chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    @(posedge clk); #1;
    bus.ID_EX_muldiv = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_len"}, 32'(bus.EX_muldiv_valid), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    bus.ID_EX_muldiv    = 1'b0;
    bus.ID_EX_muldiv_op = 3'b000;
    bus.ID_EX_rd        = 5'd0;
    bus.EX_rs1_data     = '0;
    bus.EX_rs2_data     = '0;
    bus.EX_flush        = 1'b0;
    reset_n             = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.EX_muldiv_valid), 32'd0);
    chk("rst_result", bus.EX_muldiv_result, 32'd0);
    chk("rst_rd", 32'(bus.EX_muldiv_rd), 32'd0);
    chk("rst_stall", 32'(bus.EX_stall), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Multiply family
    run_op("mul_7x-3", MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, FULL_STALL);
    run_op("mulhu_ff", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, FULL_STALL);
    run_op("mulh_ff", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, FULL_STALL);
    run_op("mulhsu_ff", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, FULL_STALL);
    run_op("mulh_min_x2", MULH, 32'h8000_0000, 32'd2, 5'd9, 32'hFFFF_FFFF, FULL_STALL);
    run_op("mul_zero", MUL, 32'd0, 32'h0001_2345, 5'd10, 32'd0, EO_STALL);

    // Divide family
    run_op("div_-7/2", DIV, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFD, FULL_STALL);
    run_op("rem_-7/2", REM, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFF, FULL_STALL);
    run_op("divu_100/7", DIVU, 32'd100, 32'd7, 5'd13, 32'd14, FULL_STALL);
    run_op("remu_100/7", REMU, 32'd100, 32'd7, 5'd14, 32'd2, FULL_STALL);
    run_op("div_-7/-2", DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd15, 32'd3, FULL_STALL);
    run_op("rem_7/-2", REM, 32'd7, 32'hFFFF_FFFE, 5'd16, 32'd1, FULL_STALL);

    // Divide by zero and signed overflow
    run_op("div_5/0", DIV, 32'd5, 32'd0, 5'd17, 32'hFFFF_FFFF, EO_STALL);
    run_op("rem_5/0", REM, 32'd5, 32'd0, 5'd18, 32'd5, EO_STALL);
    run_op("div_-5/0", DIV, 32'hFFFF_FFFB, 32'd0, 5'd19, 32'hFFFF_FFFF, EO_STALL);
    run_op("remu_5/0", REMU, 32'd5, 32'd0, 5'd20, 32'd5, EO_STALL);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, EO_STALL);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'd0, EO_STALL);

    // Flush during CALC
    @(posedge clk); #1;
    drive_req(DIVU, 32'd1000, 32'd7, 5'd23);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_flush_stall", 32'(bus.EX_stall), 32'd1);
    bus.EX_flush = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.EX_stall), 32'd0);
    @(negedge clk);
    chk("flush_valid", 32'(bus.EX_muldiv_valid), 32'd0);
    @(posedge clk); #1;
    bus.EX_flush     = 1'b0;
    bus.ID_EX_muldiv = 1'b0;
    v = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.EX_muldiv_valid) v++;
    end
    chk("flush_no_result", 32'(v), 32'd0);
    run_op("divu_9/3", DIVU, 32'd9, 32'd3, 5'd24, 32'd3, FULL_STALL);

    // Reset mid-operation
    @(posedge clk); #1;
    drive_req(MUL, 32'd9, 32'd9, 5'd25);
    repeat (6) @(posedge clk);
    #1;
    reset_n          = 1'b0;
    bus.ID_EX_muldiv = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.EX_muldiv_valid), 32'd0);
    chk("rst_mid_result", bus.EX_muldiv_result, 32'd0);
    chk("rst_mid_rd", 32'(bus.EX_muldiv_rd), 32'd0);
    chk("rst_mid_stall", 32'(bus.EX_stall), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    v = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.EX_muldiv_valid) v++;
    end
    chk("rst_no_result", 32'(v), 32'd0);
    run_op("mul_3x4", MUL, 32'd3, 32'd4, 5'd26, 32'd12, FULL_STALL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
